// File: rtl/mem_write_ctrl.sv
// Serial-to-parallel write front end for the byte memory: frame = address bits, then bytes MSB-first.
// Define MEM_WRITE_CTRL_PARITY_EN to require an even-parity bit after each data byte.
module mem_write_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              frame_end,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              wr,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] d_out,
  output logic              busy,
  output logic [7:0]        wr_count,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

`ifdef MEM_WRITE_CTRL_PARITY_EN
  localparam int LAST_BIT = DATA_W;
`else
  localparam int LAST_BIT = DATA_W - 1;
`endif
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] sh, sh_nxt, wr_data;
  logic [ADDR_W-1:0] addr_reg;
  logic              addr_done, data_last, par_ok, do_write;

  assign sh_nxt    = {sh[DATA_W-2:0], bit_in};
  assign addr_done = (state == S_ADDR) && bit_valid && (bit_cnt == CNT_W'(ADDR_W - 1));
  assign data_last = (state == S_DATA) && bit_valid && (bit_cnt == CNT_W'(LAST_BIT));

`ifdef MEM_WRITE_CTRL_PARITY_EN
  // Byte is already fully shifted in; bit_in is the parity bit.
  assign wr_data = sh;
  assign par_ok  = ~(^sh ^ bit_in);
`else
  assign wr_data = sh_nxt;
  assign par_ok  = 1'b1;
`endif

  // start outranks everything, so a restart never also writes.
  assign do_write = !start && data_last && par_ok;

  always_comb begin
    state_nxt = state;
    if (start) state_nxt = S_ADDR;
    else begin
      case (state)
        S_IDLE: state_nxt = S_IDLE;
        S_ADDR: if (frame_end) state_nxt = S_IDLE;
                else if (addr_done) state_nxt = S_DATA;
        S_DATA: if (frame_end) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      wr       <= 1'b0;
      addr_out <= '0;
      d_out    <= '0;
      wr_count <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      addr_reg <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      wr    <= do_write;
      if (start) begin
        bit_cnt  <= '0;
        sh       <= '0;
        wr_count <= '0;
      end else if (bit_valid && state != S_IDLE) begin
        sh      <= sh_nxt;
        bit_cnt <= (addr_done || data_last) ? '0 : bit_cnt + 1'b1;
      end
      if (addr_done && !start) addr_reg <= sh_nxt[ADDR_W-1:0];
      if (do_write) begin
        addr_out <= addr_reg;
        d_out    <= wr_data;
        addr_reg <= addr_reg + 1'b1;
        if (wr_count != 8'hFF) wr_count <= wr_count + 1'b1;
      end
    end
  end

`ifdef MEM_WRITE_CTRL_PARITY_EN
  always_ff @(posedge clock) begin
    if (reset || start)                   err <= 1'b0;
    else if (data_last && !par_ok)        err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_write_ctrl.sv
// Directed bench for mem_write_ctrl; expected values are hand-computed per step.
module tb_mem_write_ctrl;
  logic       clock = 1'b0;
  logic       reset, start, frame_end, bit_valid, bit_in;
  logic       wr, busy, err;
  logic [1:0] addr_out;
  logic [7:0] d_out, wr_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_wr = 0;

`ifdef MEM_WRITE_CTRL_PARITY_EN
  localparam int BYTE_BITS = 9;
`else
  localparam int BYTE_BITS = 8;
`endif

  mem_write_ctrl #(.DATA_W(8), .ADDR_W(2)) dut (
    .clock(clock), .reset(reset), .start(start), .frame_end(frame_end),
    .bit_valid(bit_valid), .bit_in(bit_in), .wr(wr), .addr_out(addr_out),
    .d_out(d_out), .busy(busy), .wr_count(wr_count), .err(err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (wr === 1'b1) n_wr <= n_wr + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bit_valid = 1'b1;
      bit_in    = v[i];
      step();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send({24'd0, b}, 8);
`ifdef MEM_WRITE_CTRL_PARITY_EN
    send({31'd0, ^b}, 1);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_end();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  int c1, n0;

  initial begin
    reset = 1'b1; start = 1'b0; frame_end = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_wr", wr, 0);
    chk("rst_addr", addr_out, 0);
    chk("rst_d", d_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", wr_count, 0);
    chk("rst_err", err, 0);

    // basic write: addr 2, byte A5
    pulse_start();
    chk("t2_busy", busy, 1);
    send(32'b10, 2);
    send_byte(8'hA5);
    chk("t2_wr", wr, 1);
    chk("t2_addr", addr_out, 2);
    chk("t2_d", d_out, 8'hA5);
    chk("t2_cnt", wr_count, 1);
    step();
    chk("t2_wr_1cyc", wr, 0);

    // reset mid-DATA after 3 bits
    pulse_start();
    send(32'b01, 2);
    send(32'b101, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t1_addr", addr_out, 0);
    chk("t1_d", d_out, 0);
    chk("t1_cnt", wr_count, 0);
    chk("t1_busy", busy, 0);
    chk("t1_wr", wr, 0);
    n0 = n_wr;
    send(32'h3FF, 10);
    step();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_nwr", n_wr, n0);

    // back-to-back bytes with address wrap 3 -> 0
    pulse_start();
    send(32'b11, 2);
    send_byte(8'h11);
    chk("t3_wr0", wr, 1);
    chk("t3_addr0", addr_out, 3);
    chk("t3_d0", d_out, 8'h11);
    c1 = cyc;
    send_byte(8'h22);
    chk("t3_wr1", wr, 1);
    chk("t3_addr1", addr_out, 0);
    chk("t3_d1", d_out, 8'h22);
    chk("t3_cnt", wr_count, 2);
    chk("t3_gap", cyc - c1, BYTE_BITS);
    pulse_end();
    chk("t3_idle", busy, 0);

    // partial byte discarded by frame_end
    step();
    n0 = n_wr;
    pulse_start();
    send(32'b00, 2);
    send(32'b10110, 5);
    pulse_end();
    chk("t4_busy", busy, 0);
    chk("t4_addr", addr_out, 0);
    chk("t4_d", d_out, 8'h22);
    chk("t4_cnt", wr_count, 0);
    step();
    chk("t4_nwr", n_wr, n0);

    // mid-byte restart with coincident bit
    pulse_start();
    send(32'b10, 2);
    send_byte(8'h5A);
    chk("t5_pre_cnt", wr_count, 1);
    send(32'b111, 3);
    start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    step();
    start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    chk("t5_cnt0", wr_count, 0);
    chk("t5_busy", busy, 1);
    send(32'b01, 2);
    send_byte(8'h3C);
    chk("t5_wr", wr, 1);
    chk("t5_addr", addr_out, 1);
    chk("t5_d", d_out, 8'h3C);
    chk("t5_cnt1", wr_count, 1);

`ifndef MEM_WRITE_CTRL_PARITY_EN
    // last data bit coincident with frame_end: still written, then idle
    send(32'h40, 7);
    bit_valid = 1'b1; bit_in = 1'b1; frame_end = 1'b1;
    step();
    bit_valid = 1'b0; bit_in = 1'b0; frame_end = 1'b0;
    chk("t7_wr", wr, 1);
    chk("t7_addr", addr_out, 2);
    chk("t7_d", d_out, 8'h81);
    chk("t7_busy", busy, 0);
`else
    pulse_end();
`endif

    // wr_count saturates at 255
    step();
    pulse_start();
    send(32'b00, 2);
    for (int i = 0; i < 256; i++) send_byte(i[7:0]);
    chk("t8_wr", wr, 1);
    chk("t8_addr", addr_out, 3);
    chk("t8_d", d_out, 8'hFF);
    chk("t8_cnt", wr_count, 8'hFF);
    pulse_end();

`ifdef MEM_WRITE_CTRL_PARITY_EN
    // parity good, parity bad, address held, start clears err
    pulse_start();
    send(32'b01, 2);
    send(32'h07, 8);
    send(32'b1, 1);
    chk("t6_wr_ok", wr, 1);
    chk("t6_addr_ok", addr_out, 1);
    chk("t6_d_ok", d_out, 8'h07);
    chk("t6_err0", err, 0);
    step();
    n0 = n_wr;
    send(32'h07, 8);
    send(32'b0, 1);
    chk("t6_wr_bad", wr, 0);
    chk("t6_err1", err, 1);
    chk("t6_cnt", wr_count, 1);
    step();
    chk("t6_nwr", n_wr, n0);
    send(32'h00, 8);
    send(32'b0, 1);
    chk("t6_wr_next", wr, 1);
    chk("t6_addr_held", addr_out, 2);
    chk("t6_err_sticky", err, 1);
    pulse_start();
    chk("t6_err_clr", err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
